// File: rtl/uart_stim_tx.sv
// UART transmitter for injecting console bytes into io_uart_rx.
// Byte FIFO in front of a start/data/parity/stop serialiser with a runtime bit period.
module uart_stim_tx #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int DIV_W      = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic [DIV_W-1:0]              div,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0] shifter, head;
  logic [DIV_W-1:0]     div_lat, cyc_cnt, div_eff;
  logic [3:0]           bit_cnt;
  logic                 par_bit;
  logic                 push, pop, fifo_empty, cyc_done, last_stop;

  assign in_ready   = (fifo_count != CW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign push       = in_valid && in_ready;
  assign cyc_done   = (cyc_cnt == '0);
  assign last_stop  = (state == STOP) && cyc_done && (bit_cnt == 4'(STOP_BITS-1));
  // Popping at the last stop cycle chains frames with no idle gap.
  assign pop        = !fifo_empty && ((state == IDLE) || last_stop);
  assign div_eff    = (div == '0) ? DIV_W'(1) : div;
  assign head       = mem[rd_ptr];
  assign busy       = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= in_data;

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
      if (in_valid && !in_ready) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      shifter <= '0;
      div_lat <= DIV_W'(1);
      par_bit <= 1'b0;
    end else if (pop) begin
      state   <= START;
      tx      <= 1'b0;
      shifter <= head;
      div_lat <= div_eff;
      cyc_cnt <= div_eff - 1'b1;
      bit_cnt <= '0;
      par_bit <= (^head) ^ (PARITY == 2);
    end else begin
      case (state)
        IDLE: tx <= 1'b1;
        START:
          if (cyc_done) begin
            state   <= DATA;
            tx      <= shifter[0];
            cyc_cnt <= div_lat - 1'b1;
          end else cyc_cnt <= cyc_cnt - 1'b1;
        DATA:
          if (cyc_done) begin
            cyc_cnt <= div_lat - 1'b1;
            if (bit_cnt == 4'(DATA_BITS-1)) begin
              bit_cnt <= '0;
              if (PARITY != 0) begin
                state <= PAR;
                tx    <= par_bit;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shifter <= shifter >> 1;
              tx      <= shifter[1];
            end
          end else cyc_cnt <= cyc_cnt - 1'b1;
        PAR:
          if (cyc_done) begin
            state   <= STOP;
            tx      <= 1'b1;
            cyc_cnt <= div_lat - 1'b1;
            bit_cnt <= '0;
          end else cyc_cnt <= cyc_cnt - 1'b1;
        STOP:
          if (cyc_done) begin
            if (bit_cnt == 4'(STOP_BITS-1)) begin
              state <= IDLE;
              tx    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              cyc_cnt <= div_lat - 1'b1;
            end
          end else cyc_cnt <= cyc_cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_stim_tx.md
Name: uart_stim_tx

Overview:
- Synthesizable UART transmitter that drives the SoC's io_uart_rx pin from a byte stream, so benches can inject console input into both harness instances.
- Bytes are accepted on a valid/ready port and buffered in a FIFO. Each byte is serialised as start, data LSB-first, optional parity and stop bits, at a runtime-programmable bit period.
- One instance is shared by the DUT and the variant harness, so both receive the same serial line and stay in lock-step.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- FIFO_DEPTH, 16, byte FIFO entries; power of two, at least 2.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- STOP_BITS, 1, stop bits per frame; 1 or 2.
- DIV_W, 16, width of the bit-period divisor.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  byte offered.
- in_ready  out  1  FIFO can accept; equals !full.
- in_data  in  DATA_BITS  byte to send.
- div  in  DIV_W  clock cycles per bit; 0 is treated as 1.
- tx  out  1  serial line to io_uart_rx; idles high.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes currently buffered.
- overflow  out  1  sticky flag; set when in_valid is high while in_ready is low.

Behaviour:
- Reset (reset==0 at a rising edge):
  - tx=1, busy=0, fifo_count=0, overflow=0, in_ready=1.
  - FIFO pointers cleared; FSM goes to IDLE.
  - Applies mid-frame too: the frame is aborted and tx is 1 from that edge on, with no partial-bit completion.
- FIFO push: in_valid && in_ready at edge E writes in_data. fifo_count increments at E.
- Full FIFO: in_ready=0, and any offered byte is dropped and sets overflow, even if a pop happens in the same cycle. Push and pop in the same cycle when not full leaves fifo_count unchanged.
- Registers: tx, bit counter, cycle counter and shift register are all registered. div is latched at frame start; changing div mid-frame has no effect until the next frame.
- FSM states:
  - IDLE: tx=1. When the FIFO is non-empty at edge E, pop the head, load the shifter, latch max(div,1), go to START, and drive tx=0 from E.
  - START: hold tx=0 for div cycles, then go to DATA with tx=shifter[0].
  - DATA: each bit is held div cycles, LSB first, for DATA_BITS bits. After the last bit go to PARITY if PARITY!=0, else STOP.
  - PARITY: even mode sends tx = XOR of the data bits; odd mode sends its inverse. Held div cycles.
  - STOP: tx=1 for STOP_BITS*div cycles. At the final stop cycle's edge:
    - FIFO non-empty: go directly to START (pop and load as from IDLE), so there is no idle gap between frames.
    - FIFO empty: go to IDLE.
- Frame length: exactly (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * div cycles.
- Byte latency: a byte accepted at edge E into an empty FIFO with the FSM in IDLE is popped at E+1, so tx falls at E+1.
- busy = (state!=IDLE) || (fifo_count!=0).
- Cycle counter width DIV_W; counts div-1 down to 0. There is no wrap hazard because div=0 is mapped to 1.
- overflow clears only on reset.

Test Plan:
- Single byte, defaults, div=4, push 0xA5: tx is 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles. Frame is 40 cycles; busy falls the cycle after the stop bit ends; fifo_count returns to 0.
- Back-to-back, div=2, push 0x00, 0xFF, 0x55 on consecutive cycles: three frames totalling 60 cycles with no idle cycle between them. fifo_count peaks at 2 (the first byte is already popped).
- Fill and overflow, div=100: push 17 bytes in 17 cycles. The first byte is popped into the FSM after 1 cycle, so fifo_count reaches 16, in_ready=0, overflow=0. One more push with in_valid=1 and in_ready=0 sets overflow=1 and fifo_count stays 16.
- Parity, PARITY=1, div=3, push 0x07: parity bit is 1 and the frame is 33 cycles. With PARITY=2 the parity bit is 0. With STOP_BITS=2 the frame is 36 cycles.
- Reset mid-frame, div=8, push 0x3C, 2 bytes queued: assert reset for 1 cycle during data bit 3. tx=1 immediately, fifo_count=0, busy=0, and no frame follows. A subsequent push of 0x81 produces a clean 80-cycle frame.
- div edge cases: div=0 behaves as div=1, giving a 10-cycle frame. Changing div from 4 to 2 mid-frame leaves the current frame at 40 cycles; the next frame is 20 cycles.
